uart_mmio_tx: RTL and testbench

// - MMIO-to-UART transmit path: the outbound counterpart of the UART programmer receiver.
// - Accepts byte writes from the Memory stage MMIO port (mmio_wea/mmio_dat) into a small FIFO.
// - Serialises each byte onto tx as 8N1: start bit, 8 data bits LSB first, 1 stop bit.
// - Sits beside the core in the top level; the core never stalls on it. Software polls the status outputs.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_mmio_tx_if.sv | 32 +++
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_mmio_tx.sv | 136 +++++++++++++
 tb/tb_uart_mmio_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the MMIO transmit path and the programmer receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_mmio_tx_if.sv
// MMIO write port and software-visible status of the UART transmitter.
interface uart_mmio_tx_if;

    logic        mmio_wea;
    logic [31:0] mmio_dat;
    logic        tx;
    logic        mmio_read;
    logic        tx_ready;
    logic        tx_idle;
    logic        overflow;

    modport master (
        output mmio_wea,
        output mmio_dat,
        input  tx,
        input  mmio_read,
        input  tx_ready,
        input  tx_idle,
        input  overflow
    );

    modport slave (
        input  mmio_wea,
        input  mmio_dat,
        output tx,
        output mmio_read,
        output tx_ready,
        output tx_idle,
        output overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO; dout follows the read pointer combinationally.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A push while full is dropped even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-to-UART transmitter: buffers byte writes in a FIFO and serialises them as 8N1 on tx.
module uart_mmio_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic           clk,
    input  logic           Rst,
    uart_mmio_tx_if.slave  bus
);

    import uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q, state_d;
    logic [15:0]    baud_q, baud_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           overflow_q, overflow_d;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           baud_last;
    logic           unused_dat_hi;

    assign unused_dat_hi = ^bus.mmio_dat[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (bus.mmio_wea),
        .pop   (fifo_pop),
        .din   (bus.mmio_dat[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (bus.mmio_wea & fifo_full);

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.mmio_read = (state_q == STOP) && baud_last;
    assign bus.tx_ready  = !fifo_full;
    assign bus.tx_idle   = (fifo_count == '0) && (state_q == IDLE);
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Bench for uart_mmio_tx: frame-timeline reference model, directed scenarios and random traffic.
module tb_uart_mmio_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic Rst = 1'b1;

    uart_mmio_tx_if bus ();

    uart_mmio_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rd_seen  = 0;
    bit chk_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the position inside the frame currently on the line.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    int         m_el   = 0;
    logic [7:0] m_cur  = '0;
    bit         m_ovf  = 1'b0;

    always @(posedge clk) begin : model_blk
        int         sz;
        bit         pop_now;
        logic [7:0] popped;
        if (Rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_el   = 0;
            m_ovf  = 1'b0;
        end else begin
            sz      = mq.size();
            pop_now = (sz > 0) && (!m_busy || m_el == FRAME - 1);
            popped  = '0;
            if (pop_now) popped = mq.pop_front();
            if (bus.mmio_wea) begin
                if (sz < DEPTH) mq.push_back(bus.mmio_dat[7:0]);
                else m_ovf = 1'b1;
            end
            if (m_busy && m_el != FRAME - 1) begin
                m_el++;
            end else if (pop_now) begin
                m_busy = 1'b1;
                m_el   = 0;
                m_cur  = popped;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_el / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    function automatic logic exp_rd();
        return m_busy && (m_el == FRAME - 1);
    endfunction

    function automatic logic exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic exp_idle();
        return (mq.size() == 0) && !m_busy;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx",        bus.tx,        exp_tx());
            check("mmio_read", bus.mmio_read, exp_rd());
            check("tx_ready",  bus.tx_ready,  exp_ready());
            check("tx_idle",   bus.tx_idle,   exp_idle());
            check("overflow",  bus.overflow,  m_ovf);
            if (bus.mmio_read) rd_seen++;
        end
    end

    // Hand-computed expectation applied to both the DUT and the model.
    task automatic pin(string name, logic act, logic mdl, logic exp);
        check({name, "_dut"}, act, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst          = 1'b1;
        bus.mmio_wea = 1'b0;
        @(negedge clk);
        Rst = 1'b0;
    endtask

    task automatic write(logic [31:0] d);
        @(negedge clk);
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = d;
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.mmio_wea = 1'b0;
    endtask

    task automatic drain(string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && !m_busy && bus.tx_idle) done = 1'b1;
        end
        check({name, "_drain"}, done, 1'b1);
    endtask

    initial begin
        int rd0;
        int r;
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;

        do_reset();
        chk_en = 1'b1;
        check("reset_tx",       bus.tx,       1'b1);
        check("reset_ready",    bus.tx_ready, 1'b1);
        check("reset_idle",     bus.tx_idle,  1'b1);
        check("reset_overflow", bus.overflow, 1'b0);

        // Single byte 0x55; cycle 0 is the write cycle.
        do_reset();
        write(32'h55);
        release_bus();
        @(negedge clk);
        pin("single_c2_start", bus.tx, exp_tx(), 1'b0);
        repeat (4) @(negedge clk);
        pin("single_c6_bit0", bus.tx, exp_tx(), 1'b1);
        repeat (4) @(negedge clk);
        pin("single_c10_bit1", bus.tx, exp_tx(), 1'b0);
        repeat (28) @(negedge clk);
        pin("single_c38_stop", bus.tx, exp_tx(), 1'b1);
        pin("single_c38_rd", bus.mmio_read, exp_rd(), 1'b0);
        repeat (3) @(negedge clk);
        pin("single_c41_rd", bus.mmio_read, exp_rd(), 1'b1);
        pin("single_c41_idle", bus.tx_idle, exp_idle(), 1'b0);
        @(negedge clk);
        pin("single_c42_idle", bus.tx_idle, exp_idle(), 1'b1);
        pin("single_c42_rd", bus.mmio_read, exp_rd(), 1'b0);

        // Back-to-back frames with no idle gap.
        do_reset();
        write(32'hA5);
        write(32'h3C);
        release_bus();
        repeat (39) @(negedge clk);
        pin("b2b_c41_rd", bus.mmio_read, exp_rd(), 1'b1);
        @(negedge clk);
        pin("b2b_c42_start", bus.tx, exp_tx(), 1'b0);
        repeat (39) @(negedge clk);
        pin("b2b_c81_rd", bus.mmio_read, exp_rd(), 1'b1);
        drain("b2b");

        // Overflow: six consecutive writes, the sixth is dropped.
        do_reset();
        rd0 = rd_seen;
        for (int i = 1; i <= 6; i++) write(32'(i));
        release_bus();
        pin("ovf_c6_flag", bus.overflow, m_ovf, 1'b1);
        pin("ovf_c6_ready", bus.tx_ready, exp_ready(), 1'b0);
        drain("ovf");
        check("ovf_frames", rd_seen - rd0, 5);
        check("ovf_sticky", bus.overflow, 1'b1);

        // Upper data bits ignored: frame carries 0x7F.
        do_reset();
        write(32'hDEADBE7F);
        release_bus();
        repeat (29) @(negedge clk);
        pin("upper_c30_bit6", bus.tx, exp_tx(), 1'b1);
        repeat (4) @(negedge clk);
        pin("upper_c34_bit7", bus.tx, exp_tx(), 1'b0);
        drain("upper");

        // Reset during data bit 3.
        do_reset();
        rd0 = rd_seen;
        write(32'hC3);
        release_bus();
        repeat (17) @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        pin("rstmid_tx", bus.tx, exp_tx(), 1'b1);
        pin("rstmid_idle", bus.tx_idle, exp_idle(), 1'b1);
        pin("rstmid_rd", bus.mmio_read, exp_rd(), 1'b0);
        Rst = 1'b0;
        check("rstmid_no_pulse", rd_seen - rd0, 0);
        write(32'h96);
        release_bus();
        drain("rstmid");
        check("rstmid_new_frame", rd_seen - rd0, 1);

        // FIFO full while the last stop cycle pops: the write is dropped.
        do_reset();
        rd0 = rd_seen;
        for (int i = 0; i < 5; i++) write(32'h10 + 32'(i));
        release_bus();
        repeat (35) @(negedge clk);
        @(negedge clk);
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = 32'h77;
        pin("fullpop_c41_rd", bus.mmio_read, exp_rd(), 1'b1);
        pin("fullpop_c41_ready", bus.tx_ready, exp_ready(), 1'b0);
        release_bus();
        pin("fullpop_c42_ovf", bus.overflow, m_ovf, 1'b1);
        pin("fullpop_c42_ready", bus.tx_ready, exp_ready(), 1'b1);
        drain("fullpop");
        check("fullpop_frames", rd_seen - rd0, 5);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 999));
            Rst = (r == 0);
            if (r < 60) begin
                bus.mmio_wea = 1'b1;
                bus.mmio_dat = $urandom;
            end else begin
                bus.mmio_wea = 1'b0;
            end
        end
        @(negedge clk);
        Rst          = 1'b0;
        bus.mmio_wea = 1'b0;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
